// File: rtl/acc_cpu_core_p_if.sv
// Memory port bundle between the accumulator core and its memory/peripheral wrapper.
//   req   : core -> mem, request; held with addr/we/wdata until ack
//   we    : core -> mem, 1 = write, 0 = read
//   addr  : core -> mem, word address
//   wdata : core -> mem, write data
//   rdata : mem -> core, read data, valid while ack=1
//   ack   : mem -> core, one-cycle completion pulse per request
interface acc_cpu_core_p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/acc_cpu_core_p.sv
// Parametrised accumulator CPU core with an external req/ack memory port,
// a hardware return stack (CALL/RET), HALT, fault reporting and an OUT strobe.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   mem          : memory port (master side)
//   pc, acc, ir  : architectural registers
//   out_data     : OUT port register, out_valid pulses for one cycle on update
//   halted       : sticky stop flag; fault: 00 none, 01 illegal, 10 overflow, 11 underflow
//
// state  | meaning
// FETCH  | read instruction at pc; ir <= rdata, pc <= pc+1
// DECODE | classify opcode, pick next state; illegal -> HALT
// IND    | ADDIND first read: pointer <= m[a]
// MEM    | data access at a (or pointer); read ops update acc
// EXEC   | single-cycle register / branch / stack ops
// HALT   | terminal until reset
module acc_cpu_core_p #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  acc_cpu_core_p_if.master    mem,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   acc,
  output logic [DATA_W-1:0]   ir,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                halted,
  output logic [1:0]          fault
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [7:0] OP_ADD   = 8'h00, OP_STORE = 8'h01, OP_LOAD = 8'h02, OP_JUMP  = 8'h03,
                         OP_JNEG  = 8'h04, OP_SUB   = 8'h05, OP_XOR  = 8'h06, OP_OR    = 8'h07,
                         OP_AND   = 8'h08, OP_JPOS  = 8'h09, OP_JZERO= 8'h0A, OP_ADDI  = 8'h0B,
                         OP_SHL   = 8'h0C, OP_SHR   = 8'h0D, OP_OUT  = 8'h0E, OP_CALL  = 8'h0F,
                         OP_RET   = 8'h10, OP_ADDIND= 8'h11, OP_HALT = 8'h12;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_IND, S_MEM, S_EXEC, S_HALT} state_t;

  state_t            state_q;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q, pc_q, ptr_q;
  logic [DATA_W-1:0] acc_q, ir_q, out_data_q;
  logic              out_valid_q, halted_q;
  logic [1:0]        fault_q;
  logic [SP_W-1:0]   sp_q;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [SH_W-1:0]   shamt;
  logic [SP_W-1:0]   sp_m1;
  logic [DATA_W-1:0] mem_result_d;
  logic              is_mem_op, is_exec_op, push_en;

  assign opcode  = ir_q[DATA_W-1 -: 8];
  assign operand = ir_q[ADDR_W-1:0];
  assign shamt   = ir_q[SH_W-1:0];
  assign sp_m1   = sp_q - SP_W'(1);
  assign push_en = (state_q == S_EXEC) && (opcode == OP_CALL) && (sp_q != SP_FULL);

  always_comb begin
    is_mem_op  = 1'b0;
    is_exec_op = 1'b0;
    case (opcode)
      OP_ADD, OP_STORE, OP_LOAD, OP_SUB, OP_XOR, OP_OR, OP_AND: is_mem_op = 1'b1;
      OP_JUMP, OP_JNEG, OP_JPOS, OP_JZERO, OP_ADDI, OP_SHL, OP_SHR,
      OP_OUT, OP_CALL, OP_RET:                                  is_exec_op = 1'b1;
      default: ;
    endcase
  end

  // Value acc takes when a read-type MEM access completes.
  always_comb begin
    mem_result_d = acc_q;
    case (opcode)
      OP_ADD, OP_ADDIND: mem_result_d = acc_q + mem.rdata;
      OP_SUB:            mem_result_d = acc_q - mem.rdata;
      OP_LOAD:           mem_result_d = mem.rdata;
      OP_XOR:            mem_result_d = acc_q ^ mem.rdata;
      OP_OR:             mem_result_d = acc_q | mem.rdata;
      OP_AND:            mem_result_d = acc_q & mem.rdata;
      default: ;
    endcase
  end

  // Stack contents need no reset; sp alone defines validity.
  always_ff @(posedge clock) begin
    if (push_en) stack_q[sp_q[IDX_W-1:0]] <= pc_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      pc_q        <= '0;
      ptr_q       <= '0;
      acc_q       <= '0;
      ir_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 2'b00;
      sp_q        <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= pc_q;
          end else if (mem.ack) begin
            req_q   <= 1'b0;
            ir_q    <= mem.rdata;
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_mem_op)                 state_q <= S_MEM;
          else if (opcode == OP_ADDIND)  state_q <= S_IND;
          else if (is_exec_op)           state_q <= S_EXEC;
          else begin
            halted_q <= 1'b1;
            fault_q  <= (opcode == OP_HALT) ? 2'b00 : 2'b01;
            state_q  <= S_HALT;
          end
        end
        S_IND: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= operand;
          end else if (mem.ack) begin
            req_q   <= 1'b0;
            ptr_q   <= mem.rdata[ADDR_W-1:0];
            state_q <= S_MEM;
          end
        end
        S_MEM: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= (opcode == OP_STORE);
            addr_q <= (opcode == OP_ADDIND) ? ptr_q : operand;
          end else if (mem.ack) begin
            req_q   <= 1'b0;
            acc_q   <= mem_result_d;
            state_q <= S_FETCH;
          end
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          case (opcode)
            OP_JUMP:  pc_q <= operand;
            OP_JNEG:  if (acc_q[DATA_W-1])  pc_q <= operand;
            OP_JPOS:  if (!acc_q[DATA_W-1]) pc_q <= operand;
            OP_JZERO: if (acc_q == '0)      pc_q <= operand;
            OP_ADDI:  acc_q <= acc_q + DATA_W'(operand);
            OP_SHL:   acc_q <= acc_q << shamt;
            OP_SHR:   acc_q <= acc_q >> shamt;
            OP_OUT: begin
              out_data_q  <= acc_q;
              out_valid_q <= 1'b1;
            end
            OP_CALL: begin
              if (sp_q == SP_FULL) begin
                halted_q <= 1'b1;
                fault_q  <= 2'b10;
                state_q  <= S_HALT;
              end else begin
                pc_q <= operand;
                sp_q <= sp_q + SP_W'(1);
              end
            end
            OP_RET: begin
              if (sp_q == '0) begin
                halted_q <= 1'b1;
                fault_q  <= 2'b11;
                state_q  <= S_HALT;
              end else begin
                pc_q <= stack_q[sp_m1[IDX_W-1:0]];
                sp_q <= sp_m1;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = acc_q;

  assign pc        = pc_q;
  assign acc       = acc_q;
  assign ir        = ir_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
endmodule

// File: tb/tb_acc_cpu_core_p.sv
module tb_acc_cpu_core_p;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pc;
  logic [15:0] acc, ir, out_data;
  logic        out_valid, halted;
  logic [1:0]  fault;

  acc_cpu_core_p_if #(.DATA_W(16), .ADDR_W(8)) bus();

  acc_cpu_core_p #(.DATA_W(16), .ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .mem(bus), .pc(pc), .acc(acc), .ir(ir),
    .out_data(out_data), .out_valid(out_valid), .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  // Memory model with fixed or random (0-7) ack latency.
  logic [15:0] mem_m [256];
  int  wait_cnt = 0, cur_lat = 0, fixed_lat = 0, writes = 0;
  bit  rand_lat = 1'b0;
  int  eff_lat;

  always_comb begin
    eff_lat   = rand_lat ? cur_lat : fixed_lat;
    bus.ack   = bus.req && (wait_cnt >= eff_lat);
    bus.rdata = mem_m[bus.addr];
  end

  always @(posedge clock) begin
    if (reset) wait_cnt <= 0;
    else if (bus.req && bus.ack) begin
      if (bus.we) begin
        mem_m[bus.addr] = bus.wdata;
        writes = writes + 1;
      end
      wait_cnt <= 0;
      cur_lat  <= $urandom_range(0, 7);
    end else if (bus.req) wait_cnt <= wait_cnt + 1;
  end

  // Monitors sampled away from the active edge.
  int   stab_err = 0, ov_count = 0, req_after_halt = 0;
  bit   prev_pending = 1'b0;
  logic [7:0]  p_addr;
  logic        p_we;
  logic [15:0] p_wd;

  always @(negedge clock) begin
    if (reset) prev_pending = 1'b0;
    else begin
      if (prev_pending && (bus.req !== 1'b1 || bus.addr !== p_addr || bus.we !== p_we || bus.wdata !== p_wd))
        stab_err = stab_err + 1;
      prev_pending = bus.req && !bus.ack;
      p_addr = bus.addr;
      p_we   = bus.we;
      p_wd   = bus.wdata;
      if (out_valid) ov_count = ov_count + 1;
      if (halted && bus.req) req_after_halt = req_after_halt + 1;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
    writes = 0;
    ov_count = 0;
    req_after_halt = 0;
    stab_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    int n = 0;
    while (!halted && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_halt_reached"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic load_t1();
    clear_mem();
    mem_m[0]  = 16'h020A; // LOAD 10
    mem_m[1]  = 16'h000B; // ADD 11
    mem_m[2]  = 16'h010C; // STORE 12
    mem_m[3]  = 16'h1200; // HALT
    mem_m[10] = 16'h0003;
    mem_m[11] = 16'h0005;
  endtask

  initial begin
    // Reset state
    clear_mem();
    reset = 1'b1;
    #1;
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_acc", {16'd0, acc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // T1: zero-wait memory
    load_t1();
    fixed_lat = 0; rand_lat = 1'b0;
    do_reset();
    run_to_halt("t1");
    chk("t1_m12", {16'd0, mem_m[12]}, 32'd8);
    chk("t1_acc", {16'd0, acc}, 32'd8);
    chk("t1_writes", writes, 32'd1);
    chk("t1_fault", {30'd0, fault}, 32'd0);
    chk("t1_pc", {24'd0, pc}, 32'd4);

    // T2: random latency, same result, bus stable while req
    load_t1();
    rand_lat = 1'b1;
    do_reset();
    run_to_halt("t2");
    chk("t2_m12", {16'd0, mem_m[12]}, 32'd8);
    chk("t2_acc", {16'd0, acc}, 32'd8);
    chk("t2_writes", writes, 32'd1);
    chk("t2_stable", stab_err, 32'd0);
    chk("t2_pc", {24'd0, pc}, 32'd4);
    rand_lat = 1'b0;

    // T3: ADDI wrap, JZERO not taken, SHL, OUT strobe
    clear_mem();
    mem_m[0]  = 16'h0214; // LOAD 20
    mem_m[1]  = 16'h0B02; // ADDI 2
    mem_m[2]  = 16'h0A1E; // JZERO 30 (not taken)
    mem_m[3]  = 16'h0C04; // SHL 4
    mem_m[4]  = 16'h0E00; // OUT
    mem_m[5]  = 16'h1200; // HALT
    mem_m[20] = 16'hFFFF;
    mem_m[30] = 16'h1200;
    fixed_lat = 1;
    do_reset();
    run_to_halt("t3");
    chk("t3_acc", {16'd0, acc}, 32'h0010);
    chk("t3_out_data", {16'd0, out_data}, 32'h0010);
    chk("t3_ov_cycles", ov_count, 32'd1);
    chk("t3_pc", {24'd0, pc}, 32'd6);
    chk("t3_out_valid_low", {31'd0, out_valid}, 32'd0);

    // T4a: nested CALLs to full depth, then RETs
    clear_mem();
    mem_m[0]  = 16'h0F0A; mem_m[1]  = 16'h1200;
    mem_m[10] = 16'h0F14; mem_m[11] = 16'h1000;
    mem_m[20] = 16'h0F1E; mem_m[21] = 16'h1000;
    mem_m[30] = 16'h0F28; mem_m[31] = 16'h1000;
    mem_m[40] = 16'h0B07; mem_m[41] = 16'h1000;
    fixed_lat = 0;
    do_reset();
    run_to_halt("t4a");
    chk("t4a_pc", {24'd0, pc}, 32'd2);
    chk("t4a_acc", {16'd0, acc}, 32'd7);
    chk("t4a_fault", {30'd0, fault}, 32'd0);

    // T4b: one CALL beyond depth -> overflow
    mem_m[40] = 16'h0F32; // CALL 50
    do_reset();
    run_to_halt("t4b");
    chk("t4b_fault", {30'd0, fault}, 32'd2);
    chk("t4b_pc", {24'd0, pc}, 32'd41);
    repeat (20) @(negedge clock);
    chk("t4b_no_req", req_after_halt, 32'd0);

    // T5: RET on empty stack, then illegal opcode
    clear_mem();
    mem_m[0] = 16'h1000;
    do_reset();
    run_to_halt("t5a");
    chk("t5a_fault", {30'd0, fault}, 32'd3);
    chk("t5a_pc", {24'd0, pc}, 32'd1);
    repeat (20) @(negedge clock);
    chk("t5a_no_req", req_after_halt, 32'd0);
    clear_mem();
    mem_m[0] = 16'h3F00;
    do_reset();
    run_to_halt("t5b");
    chk("t5b_fault", {30'd0, fault}, 32'd1);
    repeat (20) @(negedge clock);
    chk("t5b_no_req", req_after_halt, 32'd0);
    chk("t5b_halted", {31'd0, halted}, 32'd1);

    // T6: reset mid-MEM with a pending request
    load_t1();
    fixed_lat = 5;
    do_reset();
    begin
      int n = 0;
      while (!(bus.req && !bus.we && bus.addr == 8'd10) && n < 200) begin
        @(negedge clock);
        n++;
      end
      chk("t6_mem_phase_seen", {31'd0, bus.req}, 32'd1);
    end
    reset = 1'b1;
    #1;
    chk("t6_req_drop", {31'd0, bus.req}, 32'd0);
    chk("t6_pc", {24'd0, pc}, 32'd0);
    chk("t6_ir", {16'd0, ir}, 32'd0);
    chk("t6_acc", {16'd0, acc}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    begin
      int n = 0;
      while (!bus.req && n < 20) begin
        @(negedge clock);
        n++;
      end
      chk("t6_refetch_req", {31'd0, bus.req}, 32'd1);
      chk("t6_refetch_addr", {24'd0, bus.addr}, 32'd0);
    end
    run_to_halt("t6");
    chk("t6_acc_final", {16'd0, acc}, 32'd8);
    chk("t6_m12", {16'd0, mem_m[12]}, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
